// File: rtl/design1_wrapper.sv
// design1_wrapper: Cartesian-to-polar remap subsystem for the spinning LED display.
// An AXI4-Lite master shell (design_1_i.axi_vip_0) drives a memory-mapped c2p slave.
// Software loads a Cartesian image and a polar-to-Cartesian map table. It then reads
// remapped polar pixels from the window at 0xC000_0000.
// Ports (top): sys_clock - system clock; reset - asynchronous active-low reset.

// AXI4-Lite bus bundle; the master-side members are driven from outside the RTL.
interface axi_vip_if;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
endinterface

// c2p slave: register bank, map table, image memory and polar read window.
// Ports: clk_i/rst_ni, AXI4-Lite slave AW/W/B/AR/R channels (WSTRB and PROT not used).
module c2p_slave (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] awaddr_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] wdata_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i,
    input  logic [31:0] araddr_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rvalid_o,
    input  logic        rready_i
);
    localparam int unsigned IMG_DEPTH = 256;
    localparam int unsigned MAP_DEPTH = 256;
    localparam int unsigned IDX_W     = 8;

    logic [31:0]      image_q [IMG_DEPTH];
    logic [IDX_W-1:0] map_q   [MAP_DEPTH];

    logic             aw_rdy_q, aw_rdy_d;
    logic             b_valid_q, b_valid_d;
    logic             strobe_q, strobe_d;
    logic [31:0]      inp_image_q, inp_image_d;
    logic [31:0]      w_addr_q, w_addr_d;
    logic [IDX_W-1:0] map_ptr_q, map_ptr_d;
    logic             ar_rdy_q, ar_rdy_d;
    logic             rd_busy_q, rd_busy_d;
    logic             polar_pend_q, polar_pend_d;
    logic [IDX_W-1:0] polar_idx_q, polar_idx_d;
    logic             r_valid_q, r_valid_d;
    logic [31:0]      r_data_q, r_data_d;

    logic wr_fire, rd_fire, wr_polar, rd_polar, map_we;
    logic unused_addr_bits;

    assign wr_fire  = aw_rdy_q && awvalid_i && wvalid_i;
    assign rd_fire  = ar_rdy_q && arvalid_i;
    assign wr_polar = (awaddr_i[31:30] == 2'b11);
    assign rd_polar = (araddr_i[31:30] == 2'b11);
    assign map_we   = wr_fire && !wr_polar && (awaddr_i[3:2] == 2'd0);
    assign unused_addr_bits = ^{awaddr_i[29:4], awaddr_i[1:0], araddr_i[29:10], araddr_i[1:0]};

    // Next-state logic for both channels.
    always_comb begin
        aw_rdy_d     = awvalid_i && wvalid_i && !aw_rdy_q && !b_valid_q;
        b_valid_d    = b_valid_q;
        strobe_d     = 1'b0;
        inp_image_d  = inp_image_q;
        w_addr_d     = w_addr_q;
        map_ptr_d    = map_ptr_q;
        ar_rdy_d     = arvalid_i && !ar_rdy_q && !rd_busy_q;
        rd_busy_d    = rd_busy_q;
        polar_pend_d = 1'b0;
        polar_idx_d  = polar_idx_q;
        r_valid_d    = r_valid_q;
        r_data_d     = r_data_q;

        if (b_valid_q && bready_i) begin
            b_valid_d = 1'b0;
        end
        if (wr_fire) begin
            b_valid_d = 1'b1;
            if (!wr_polar) begin
                case (awaddr_i[3:2])
                    2'd0:    map_ptr_d   = map_ptr_q + IDX_W'(1);
                    2'd1:    inp_image_d = wdata_i;
                    2'd2:    w_addr_d    = wdata_i;
                    default: strobe_d    = wdata_i[0];
                endcase
            end
        end

        if (rd_fire) begin
            rd_busy_d = 1'b1;
            if (rd_polar) begin
                // First lookup: polar index -> Cartesian index.
                polar_pend_d = 1'b1;
                polar_idx_d  = map_q[araddr_i[9:2]];
            end else begin
                r_valid_d = 1'b1;
                case (araddr_i[3:2])
                    2'd0:    r_data_d = {24'b0, map_ptr_q};
                    2'd1:    r_data_d = inp_image_q;
                    2'd2:    r_data_d = w_addr_q;
                    default: r_data_d = 32'b0;
                endcase
            end
        end
        if (polar_pend_q) begin
            // Second lookup: Cartesian index -> pixel.
            r_valid_d = 1'b1;
            r_data_d  = image_q[polar_idx_q];
        end
        if (r_valid_q && rready_i) begin
            r_valid_d = 1'b0;
            rd_busy_d = 1'b0;
        end
    end

    // Control and register state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_rdy_q     <= 1'b0;
            b_valid_q    <= 1'b0;
            strobe_q     <= 1'b0;
            inp_image_q  <= 32'b0;
            w_addr_q     <= 32'b0;
            map_ptr_q    <= '0;
            ar_rdy_q     <= 1'b0;
            rd_busy_q    <= 1'b0;
            polar_pend_q <= 1'b0;
            polar_idx_q  <= '0;
            r_valid_q    <= 1'b0;
            r_data_q     <= 32'b0;
        end else begin
            aw_rdy_q     <= aw_rdy_d;
            b_valid_q    <= b_valid_d;
            strobe_q     <= strobe_d;
            inp_image_q  <= inp_image_d;
            w_addr_q     <= w_addr_d;
            map_ptr_q    <= map_ptr_d;
            ar_rdy_q     <= ar_rdy_d;
            rd_busy_q    <= rd_busy_d;
            polar_pend_q <= polar_pend_d;
            polar_idx_q  <= polar_idx_d;
            r_valid_q    <= r_valid_d;
            r_data_q     <= r_data_d;
        end
    end

    // Memories keep their contents across reset.
    always_ff @(posedge clk_i) begin
        if (map_we) begin
            map_q[map_ptr_q] <= wdata_i[7:0];
        end
        if (strobe_q) begin
            image_q[w_addr_q[7:0]] <= inp_image_q;
        end
    end

    assign awready_o = aw_rdy_q;
    assign wready_o  = aw_rdy_q;
    assign bvalid_o  = b_valid_q;
    assign bresp_o   = 2'b00;
    assign arready_o = ar_rdy_q;
    assign rvalid_o  = r_valid_q;
    assign rdata_o   = r_data_q;
    assign rresp_o   = 2'b00;
endmodule

// Master core: exposes the bus bundle IF and bridges it to master ports.
// Ports: m_*_o master requests taken from IF, m_*_i slave responses fed into IF.
module axi_vip_core (
    output logic [31:0] m_awaddr_o,
    output logic        m_awvalid_o,
    input  logic        m_awready_i,
    output logic [31:0] m_wdata_o,
    output logic        m_wvalid_o,
    input  logic        m_wready_i,
    input  logic [1:0]  m_bresp_i,
    input  logic        m_bvalid_i,
    output logic        m_bready_o,
    output logic [31:0] m_araddr_o,
    output logic        m_arvalid_o,
    input  logic        m_arready_i,
    input  logic [31:0] m_rdata_i,
    input  logic [1:0]  m_rresp_i,
    input  logic        m_rvalid_i,
    output logic        m_rready_o
);
    axi_vip_if IF ();

    assign m_awaddr_o  = IF.AWADDR;
    assign m_awvalid_o = IF.AWVALID;
    assign m_wdata_o   = IF.WDATA;
    assign m_wvalid_o  = IF.WVALID;
    assign m_bready_o  = IF.BREADY;
    assign m_araddr_o  = IF.ARADDR;
    assign m_arvalid_o = IF.ARVALID;
    assign m_rready_o  = IF.RREADY;
    assign IF.AWREADY  = m_awready_i;
    assign IF.WREADY   = m_wready_i;
    assign IF.BRESP    = m_bresp_i;
    assign IF.BVALID   = m_bvalid_i;
    assign IF.ARREADY  = m_arready_i;
    assign IF.RDATA    = m_rdata_i;
    assign IF.RRESP    = m_rresp_i;
    assign IF.RVALID   = m_rvalid_i;
endmodule

// VIP shell so the bundle sits at axi_vip_0.inst.IF.
module axi_vip_master (
    output logic [31:0] m_awaddr_o,
    output logic        m_awvalid_o,
    input  logic        m_awready_i,
    output logic [31:0] m_wdata_o,
    output logic        m_wvalid_o,
    input  logic        m_wready_i,
    input  logic [1:0]  m_bresp_i,
    input  logic        m_bvalid_i,
    output logic        m_bready_o,
    output logic [31:0] m_araddr_o,
    output logic        m_arvalid_o,
    input  logic        m_arready_i,
    input  logic [31:0] m_rdata_i,
    input  logic [1:0]  m_rresp_i,
    input  logic        m_rvalid_i,
    output logic        m_rready_o
);
    axi_vip_core inst (.*);
endmodule

// Block design: VIP master wired point-to-point to the c2p slave.
module design_1 (
    input logic clk_i,
    input logic rst_ni
);
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    axi_vip_master axi_vip_0 (
        .m_awaddr_o (awaddr),  .m_awvalid_o(awvalid), .m_awready_i(awready),
        .m_wdata_o  (wdata),   .m_wvalid_o (wvalid),  .m_wready_i (wready),
        .m_bresp_i  (bresp),   .m_bvalid_i (bvalid),  .m_bready_o (bready),
        .m_araddr_o (araddr),  .m_arvalid_o(arvalid), .m_arready_i(arready),
        .m_rdata_i  (rdata),   .m_rresp_i  (rresp),   .m_rvalid_i (rvalid),
        .m_rready_o (rready)
    );

    c2p_slave c2p_0 (
        .clk_i    (clk_i),   .rst_ni   (rst_ni),
        .awaddr_i (awaddr),  .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i  (wdata),   .wvalid_i (wvalid),  .wready_o (wready),
        .bresp_o  (bresp),   .bvalid_o (bvalid),  .bready_i (bready),
        .araddr_i (araddr),  .arvalid_i(arvalid), .arready_o(arready),
        .rdata_o  (rdata),   .rresp_o  (rresp),   .rvalid_o (rvalid),
        .rready_i (rready)
    );
endmodule

// Top: only clock and reset are exposed.
module design1_wrapper (
    input logic sys_clock,
    input logic reset
);
    design_1 design_1_i (
        .clk_i (sys_clock),
        .rst_ni(reset)
    );
endmodule

// File: tb/tb_design1_wrapper.sv
// Directed bench for design1_wrapper: drives AXI4-Lite through design_1_i.axi_vip_0.inst.IF.
module tb_design1_wrapper;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    design1_wrapper dut (
        .sys_clock(clk),
        .reset    (rst_n)
    );

    typedef enum int {OP_RD, OP_WR, OP_WRAP} op_e;
    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] data;
        string       name;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input op_e op, input logic [31:0] a, input logic [31:0] d, input string n);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present AW+W until the handshake edge has passed.
    task automatic wr_req(input logic [31:0] a, input logic [31:0] d, output bit ok);
        int n = 0;
        dut.design_1_i.axi_vip_0.inst.IF.AWADDR  = a;
        dut.design_1_i.axi_vip_0.inst.IF.WDATA   = d;
        dut.design_1_i.axi_vip_0.inst.IF.AWVALID = 1'b1;
        dut.design_1_i.axi_vip_0.inst.IF.WVALID  = 1'b1;
        ok = 1'b0;
        while (!ok && n < 20) begin
            @(posedge clk); #1;
            n++;
            ok = dut.design_1_i.axi_vip_0.inst.IF.AWREADY && dut.design_1_i.axi_vip_0.inst.IF.WREADY;
        end
        if (ok) begin
            @(posedge clk); #1;
        end
        dut.design_1_i.axi_vip_0.inst.IF.AWVALID = 1'b0;
        dut.design_1_i.axi_vip_0.inst.IF.WVALID  = 1'b0;
    endtask

    task automatic wait_bvalid(output bit ok);
        int n = 0;
        while (!dut.design_1_i.axi_vip_0.inst.IF.BVALID && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ok = dut.design_1_i.axi_vip_0.inst.IF.BVALID;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input string n);
        bit ok;
        dut.design_1_i.axi_vip_0.inst.IF.BREADY = 1'b1;
        wr_req(a, d, ok);
        check({n, "_wr_handshake"}, 32'(ok), 32'd1);
        wait_bvalid(ok);
        check({n, "_bvalid"}, 32'(ok), 32'd1);
        check({n, "_bresp"}, 32'(dut.design_1_i.axi_vip_0.inst.IF.BRESP), 32'd0);
        @(posedge clk); #1;
    endtask

    // Issue one read; RREADY is high throughout.
    task automatic axi_read(input logic [31:0] a, output logic [31:0] data, input string n);
        int c = 0;
        dut.design_1_i.axi_vip_0.inst.IF.RREADY  = 1'b1;
        dut.design_1_i.axi_vip_0.inst.IF.ARADDR  = a;
        dut.design_1_i.axi_vip_0.inst.IF.ARVALID = 1'b1;
        while (!dut.design_1_i.axi_vip_0.inst.IF.ARREADY && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        check({n, "_arready"}, 32'(dut.design_1_i.axi_vip_0.inst.IF.ARREADY), 32'd1);
        @(posedge clk); #1;
        dut.design_1_i.axi_vip_0.inst.IF.ARVALID = 1'b0;
        c = 0;
        while (!dut.design_1_i.axi_vip_0.inst.IF.RVALID && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        check({n, "_rvalid"}, 32'(dut.design_1_i.axi_vip_0.inst.IF.RVALID), 32'd1);
        check({n, "_rresp"}, 32'(dut.design_1_i.axi_vip_0.inst.IF.RRESP), 32'd0);
        data = dut.design_1_i.axi_vip_0.inst.IF.RDATA;
        @(posedge clk); #1;
    endtask

    task automatic read_check(input logic [31:0] a, input logic [31:0] exp, input string n);
        logic [31:0] d;
        axi_read(a, d, n);
        check(n, d, exp);
    endtask

    task automatic check_idle(input string n);
        check({n, "_awready"}, 32'(dut.design_1_i.axi_vip_0.inst.IF.AWREADY), 32'd0);
        check({n, "_wready"},  32'(dut.design_1_i.axi_vip_0.inst.IF.WREADY),  32'd0);
        check({n, "_bvalid"},  32'(dut.design_1_i.axi_vip_0.inst.IF.BVALID),  32'd0);
        check({n, "_arready"}, 32'(dut.design_1_i.axi_vip_0.inst.IF.ARREADY), 32'd0);
        check({n, "_rvalid"},  32'(dut.design_1_i.axi_vip_0.inst.IF.RVALID),  32'd0);
        check({n, "_rdata"},   dut.design_1_i.axi_vip_0.inst.IF.RDATA,        32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [31:0] rd;
        dut.design_1_i.axi_vip_0.inst.IF.AWADDR  = '0;
        dut.design_1_i.axi_vip_0.inst.IF.AWVALID = 1'b0;
        dut.design_1_i.axi_vip_0.inst.IF.WDATA   = '0;
        dut.design_1_i.axi_vip_0.inst.IF.WVALID  = 1'b0;
        dut.design_1_i.axi_vip_0.inst.IF.BREADY  = 1'b1;
        dut.design_1_i.axi_vip_0.inst.IF.ARADDR  = '0;
        dut.design_1_i.axi_vip_0.inst.IF.ARVALID = 1'b0;
        dut.design_1_i.axi_vip_0.inst.IF.RREADY  = 1'b1;

        // Expected values derived from the register/map/image model by hand.
        add(OP_RD, 32'h0000_0000, 32'd0, "rst_map_ptr");
        add(OP_RD, 32'h0000_0004, 32'd0, "rst_inp_image");
        add(OP_RD, 32'h0000_0008, 32'd0, "rst_w_addr");
        add(OP_RD, 32'h0000_000C, 32'd0, "rst_inp_valid");
        add(OP_RD, 32'hC000_0000, 32'd0, "rst_polar0");
        add(OP_WR, 32'h0000_0000, 32'd6, "map_w6");
        add(OP_WR, 32'h0000_0000, 32'd7, "map_w7");
        add(OP_RD, 32'h0000_0000, 32'd2, "map_ptr_2");
        add(OP_RD, 32'hC000_0000, 32'd0, "polar0_idx6");
        add(OP_RD, 32'hC000_0004, 32'd0, "polar1_idx7");
        add(OP_WR, 32'h0000_0004, 32'd5, "img_data5");
        add(OP_WR, 32'h0000_0008, 32'd4, "img_addr4");
        add(OP_WR, 32'h0000_000C, 32'd1, "strobe_4");
        add(OP_RD, 32'h0000_000C, 32'd0, "inp_valid_rd0");
        add(OP_RD, 32'h0000_0004, 32'd5, "inp_image_5");
        add(OP_RD, 32'h0000_0008, 32'd4, "w_addr_4");
        add(OP_WR, 32'h0000_0000, 32'd4, "map2_w4");
        add(OP_RD, 32'hC000_0008, 32'd5, "polar2_img4");
        add(OP_RD, 32'hC000_0000, 32'd0, "polar0_again");
        add(OP_RD, 32'h0000_0010, 32'd3, "alias_map_ptr");
        add(OP_RD, 32'h0000_0016, 32'd5, "alias_inp_image");
        add(OP_WR, 32'hC000_0008, 32'h0000_DEAD, "polar_wr_drop");
        add(OP_RD, 32'hC000_0008, 32'd5, "polar2_unchanged");
        add(OP_RD, 32'h0000_0000, 32'd3, "map_ptr_still3");
        add(OP_WR, 32'h0000_0004, 32'd9, "img_data9");
        add(OP_WR, 32'h0000_000C, 32'd2, "no_strobe_bit0");
        add(OP_RD, 32'hC000_0008, 32'd5, "img4_kept");
        add(OP_WR, 32'h0000_0008, 32'd6, "img_addr6");
        add(OP_WR, 32'h0000_000C, 32'd1, "strobe_6");
        add(OP_RD, 32'hC000_0000, 32'd9, "polar0_img6");
        add(OP_WR, 32'h0000_0004, 32'h0000_00AB, "img_dataAB");
        add(OP_WR, 32'h0000_0008, 32'h0000_00FE, "img_addrFE");
        add(OP_WR, 32'h0000_000C, 32'd1, "strobe_FE");
        add(OP_WR, 32'h0000_0004, 32'h0000_00CD, "img_dataCD");
        add(OP_WR, 32'h0000_0008, 32'h0000_00FF, "img_addrFF");
        add(OP_WR, 32'h0000_000C, 32'd1, "strobe_FF");
        // 256 map writes starting at ptr 3: map[p] = (p-3) & 0xFF afterwards.
        add(OP_WRAP, 32'h0000_0000, 32'd0, "map_wrap");
        add(OP_RD, 32'h0000_0000, 32'd3, "wrap_ptr_3");
        add(OP_RD, 32'hC000_0004, 32'h0000_00AB, "wrap_map1_254");
        add(OP_RD, 32'hC000_0008, 32'h0000_00CD, "wrap_map2_255");
        add(OP_RD, 32'hC000_000C, 32'd0, "wrap_map3_0");
        add(OP_RD, 32'hC000_001C, 32'd5, "wrap_map7_4");
        add(OP_RD, 32'hC000_0024, 32'd9, "wrap_map9_6");

        repeat (2) @(posedge clk);
        #1;
        check_idle("in_reset");
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_RD: read_check(vecs[i].addr, vecs[i].data, vecs[i].name);
                OP_WR: axi_write(vecs[i].addr, vecs[i].data, vecs[i].name);
                default: begin
                    for (int k = 0; k < 256; k++) begin
                        axi_write(vecs[i].addr, 32'(k), vecs[i].name);
                    end
                end
            endcase
        end

        // BREADY held low: BVALID holds and a second write is not taken.
        dut.design_1_i.axi_vip_0.inst.IF.BREADY = 1'b0;
        wr_req(32'h0000_0008, 32'h0000_0011, ok);
        check("hold_wr_handshake", 32'(ok), 32'd1);
        wait_bvalid(ok);
        check("hold_bvalid_rise", 32'(ok), 32'd1);
        dut.design_1_i.axi_vip_0.inst.IF.AWADDR  = 32'h0000_0004;
        dut.design_1_i.axi_vip_0.inst.IF.WDATA   = 32'h0000_0077;
        dut.design_1_i.axi_vip_0.inst.IF.AWVALID = 1'b1;
        dut.design_1_i.axi_vip_0.inst.IF.WVALID  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("hold_bvalid", 32'(dut.design_1_i.axi_vip_0.inst.IF.BVALID), 32'd1);
            check("hold_awready", 32'(dut.design_1_i.axi_vip_0.inst.IF.AWREADY), 32'd0);
        end
        dut.design_1_i.axi_vip_0.inst.IF.AWVALID = 1'b0;
        dut.design_1_i.axi_vip_0.inst.IF.WVALID  = 1'b0;
        dut.design_1_i.axi_vip_0.inst.IF.BREADY  = 1'b1;
        @(posedge clk); #1;
        check("hold_bvalid_drop", 32'(dut.design_1_i.axi_vip_0.inst.IF.BVALID), 32'd0);
        read_check(32'h0000_0004, 32'h0000_00CD, "hold_second_dropped");
        read_check(32'h0000_0008, 32'h0000_0011, "hold_w_addr");

        // RREADY held low: RVALID/RDATA stable and no second read accepted.
        dut.design_1_i.axi_vip_0.inst.IF.RREADY  = 1'b0;
        dut.design_1_i.axi_vip_0.inst.IF.ARADDR  = 32'h0000_0008;
        dut.design_1_i.axi_vip_0.inst.IF.ARVALID = 1'b1;
        begin
            int c = 0;
            while (!dut.design_1_i.axi_vip_0.inst.IF.ARREADY && c < 20) begin
                @(posedge clk); #1;
                c++;
            end
        end
        check("rhold_arready", 32'(dut.design_1_i.axi_vip_0.inst.IF.ARREADY), 32'd1);
        @(posedge clk); #1;
        dut.design_1_i.axi_vip_0.inst.IF.ARADDR = 32'h0000_0004;
        check("rhold_rvalid_rise", 32'(dut.design_1_i.axi_vip_0.inst.IF.RVALID), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("rhold_rvalid", 32'(dut.design_1_i.axi_vip_0.inst.IF.RVALID), 32'd1);
            check("rhold_rdata", dut.design_1_i.axi_vip_0.inst.IF.RDATA, 32'h0000_0011);
            check("rhold_arready_low", 32'(dut.design_1_i.axi_vip_0.inst.IF.ARREADY), 32'd0);
        end
        dut.design_1_i.axi_vip_0.inst.IF.ARVALID = 1'b0;
        dut.design_1_i.axi_vip_0.inst.IF.RREADY  = 1'b1;
        @(posedge clk); #1;
        check("rhold_rvalid_drop", 32'(dut.design_1_i.axi_vip_0.inst.IF.RVALID), 32'd0);

        // Reset during a pending BVALID; map[3]=4 is already written.
        dut.design_1_i.axi_vip_0.inst.IF.BREADY = 1'b0;
        wr_req(32'h0000_0000, 32'd4, ok);
        check("rst_wr_handshake", 32'(ok), 32'd1);
        wait_bvalid(ok);
        check("rst_bvalid_pending", 32'(ok), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dut.design_1_i.axi_vip_0.inst.IF.BREADY = 1'b1;
        @(posedge clk); #1;
        read_check(32'h0000_0000, 32'd0, "post_rst_map_ptr");
        read_check(32'h0000_0004, 32'd0, "post_rst_inp_image");
        read_check(32'h0000_0008, 32'd0, "post_rst_w_addr");
        read_check(32'hC000_000C, 32'd5, "post_rst_map3_kept");
        read_check(32'hC000_0004, 32'h0000_00AB, "post_rst_img_kept");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
